// File: rtl/litedram_native_pkg.sv
// litedram_native_pkg: shared defaults and FSM state encoding for the native reader
package litedram_native_pkg;
    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 256;
    localparam int LEN_W_DEF  = 16;
    localparam int DEPTH_DEF  = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/native_reader_fifo.sv
// native_reader_fifo: registered sync FIFO holding {last,data} words with occupancy count
module native_reader_fifo #(
    parameter int W     = 257,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          user_clk,
    input  logic          user_rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    assign rdata = mem[rd_ptr];
    assign empty = count == '0;
    // storage array; contents are only meaningful while count is nonzero
    always_ff @(posedge user_clk)
        if (push) mem[wr_ptr] <= wdata;
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge user_clk)
        if (user_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

// File: rtl/litedram_native_reader.sv
// litedram_native_reader: credit-limited read master streaming native-port data in request order
module litedram_native_reader
    import litedram_native_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              rdata_valid,
    output logic              rdata_ready,
    input  logic [DATA_W-1:0] rdata_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  received;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     count;
    logic [DATA_W:0]   head;
    logic              empty;
    logic              credit_ok;
    logic              cmd_fire;
    logic              rd_fire;
    logic              out_fire;
    assign busy        = state != IDLE;
    assign req_ready   = state == IDLE;
    assign rdata_ready = busy;
    assign cmd_we      = 1'b0;
    assign cmd_addr    = addr;
    assign credit_ok   = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(DEPTH);
    assign cmd_valid   = state == ISSUE && credit_ok;
    assign cmd_fire    = cmd_valid & cmd_ready;
    assign rd_fire     = rdata_valid & rdata_ready;
    assign out_valid   = !empty;
    assign out_data    = head[DATA_W-1:0];
    assign out_last    = head[DATA_W] & !empty;
    assign out_fire    = out_valid & out_ready;
    native_reader_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
        .user_clk (user_clk),
        .user_rst (user_rst),
        .push     (rd_fire),
        .wdata    ({received == len - LEN_W'(1), rdata_data}),
        .pop      (out_fire),
        .rdata    (head),
        .count    (count),
        .empty    (empty)
    );
    // request FSM with address, issue/receive counters and reserved-slot tracking
    always_ff @(posedge user_clk)
        if (user_rst) begin
            state    <= IDLE;
            addr     <= '0;
            len      <= '0;
            issued   <= '0;
            received <= '0;
            inflight <= '0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= inflight + CW'(cmd_fire) - CW'(rd_fire);
            if (rd_fire) received <= received + LEN_W'(1);
            case (state)
                IDLE:
                    if (req_valid) begin
                        if (req_len != '0) begin
                            state    <= ISSUE;
                            addr     <= req_addr;
                            len      <= req_len;
                            issued   <= '0;
                            received <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                ISSUE:
                    if (cmd_fire) begin
                        addr   <= addr + ADDR_W'(1);
                        issued <= issued + LEN_W'(1);
                        if (issued == len - LEN_W'(1)) state <= DRAIN;
                    end
                DRAIN:
                    if (out_fire && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_litedram_native_reader.sv
// tb_litedram_native_reader: table-driven and randomized checks against a queue-based reference model
module tb_litedram_native_reader;
    localparam int AW = 24;
    localparam int DW = 256;
    localparam int LW = 16;
    localparam int DEPTH = 8;

    logic          user_clk = 1'b0;
    logic          user_rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic          rdata_valid = 1'b0;
    logic          rdata_ready;
    logic [DW-1:0] rdata_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 user_clk = ~user_clk;

    litedram_native_reader dut (
        .user_clk    (user_clk),
        .user_rst    (user_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata_data  (rdata_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    typedef struct { logic [AW-1:0] a; int due; } rsp_t;
    typedef struct { logic [DW-1:0] d; bit last; } ow_t;
    typedef struct {
        logic [AW-1:0] addr; logic [LW-1:0] len; int crm; int orm;
        int ncmd; logic [AW-1:0] first_a; logic [AW-1:0] last_a; bit tight;
    } vec_t;

    int vec = 0, errs = 0, cyc = 0;
    int crm = 0, orm = 0;
    bit rq_pend = 0, rst_pend = 0;
    logic [AW-1:0] rq_addr = '0;
    logic [LW-1:0] rq_len = '0;
    rsp_t ctl_q[$];
    logic [AW-1:0] exp_cmd[$];
    ow_t exp_out[$];
    bit act = 0, done_nxt = 0, cmd_pend = 0, out_pend = 0, rd_prev = 0;
    int accepted = 0, popped = 0, last_due = 0;
    int ncmd, nout, ndone, req_cyc, first_cyc, last_cyc;
    logic [AW-1:0] first_a, last_a;
    vec_t tbl[6];

    // memory contents as seen through the native port: lane 0 of word 0 is ffff_0000
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        logic [DW-1:0] m;
        for (int i = 0; i < 8; i++) m[i*32 +: 32] = {~a[15:0], a[15:0]} ^ {8'(i), a[23:16], 16'h0};
        return m;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        vec++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic observe();
        ow_t ow;
        int d;
        if (user_rst) begin
            ctl_q.delete(); exp_cmd.delete(); exp_out.delete();
            act = 0; done_nxt = 0; cmd_pend = 0; out_pend = 0; rd_prev = 0;
            accepted = 0; popped = 0;
            return;
        end
        chk("busy", busy, act);
        chk("req_ready", req_ready, !act);
        chk("rdata_ready", rdata_ready, act);
        chk("done", done, done_nxt);
        chk("cmd_we", cmd_we, 0);
        if (cmd_pend) chk("cmd_hold", cmd_valid, 1);
        if (out_pend) chk("out_hold", out_valid, 1);
        if (rd_prev) chk("rd_to_out", out_valid, 1);
        if (done) ndone++;
        done_nxt = 0;
        if (cmd_valid && cmd_ready) begin
            chk("credit", accepted - popped < DEPTH, 1);
            if (exp_cmd.size() == 0) begin
                vec++; errs++;
                $display("FAIL cmd_extra: got addr %0h want no command", cmd_addr);
            end else chk("cmd_addr", cmd_addr, exp_cmd.pop_front());
            d = cyc + $urandom_range(1, 5);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            ctl_q.push_back('{a: cmd_addr, due: d});
            if (ncmd == 0) begin first_a = cmd_addr; first_cyc = cyc; end
            last_a = cmd_addr; last_cyc = cyc;
            accepted++; ncmd++;
        end
        cmd_pend = cmd_valid && !cmd_ready;
        rd_prev = rdata_valid && rdata_ready;
        if (rd_prev) void'(ctl_q.pop_front());
        if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                vec++; errs++;
                $display("FAIL out_extra: got word %0h want no word", out_data);
            end else begin
                ow = exp_out.pop_front();
                chk("out_data", out_data, ow.d);
                chk("out_last", out_last, ow.last);
                if (ow.last) begin done_nxt = 1; act = 0; end
            end
            popped++; nout++;
        end
        out_pend = out_valid && !out_ready;
        if (req_valid && req_ready) begin
            rq_pend = 0; req_cyc = cyc; accepted = 0; popped = 0;
            if (req_len == 0) done_nxt = 1;
            else begin
                act = 1;
                for (int i = 0; i < int'(req_len); i++) begin
                    exp_cmd.push_back(req_addr + AW'(i));
                    exp_out.push_back('{d: mem(req_addr + AW'(i)), last: (i == int'(req_len) - 1)});
                end
            end
        end
    endtask

    task automatic step();
        @(negedge user_clk);
        user_rst = rst_pend; rst_pend = 0;
        req_valid = rq_pend; req_addr = rq_addr; req_len = rq_len;
        cmd_ready = (crm == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        out_ready = (orm == 0) ? 1'b1 : (orm == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
        if (ctl_q.size() > 0 && ctl_q[0].due <= cyc) begin
            rdata_valid = 1'b1; rdata_data = mem(ctl_q[0].a);
        end else begin
            rdata_valid = 1'b0; rdata_data = {8{$urandom()}};
        end
        #1;
        observe();
        cyc++;
    endtask

    task automatic start_req(input logic [AW-1:0] a, input logic [LW-1:0] l);
        ncmd = 0; nout = 0; ndone = 0; first_cyc = -1; last_cyc = -1;
        rq_addr = a; rq_len = l; rq_pend = 1;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 3000 && ndone == 0; n++) step();
        repeat (3) step();
        chk("done_seen", ndone, 1);
        chk("model_drained", exp_out.size(), 0);
    endtask

    initial begin
        tbl[0] = '{24'h000000, 16'd1,  0, 0, 1,  24'h000000, 24'h000000, 1};
        tbl[1] = '{24'h000008, 16'd4,  0, 0, 4,  24'h000008, 24'h00000B, 1};
        tbl[2] = '{24'hFFFFFE, 16'd4,  0, 0, 4,  24'hFFFFFE, 24'h000001, 1};
        tbl[3] = '{24'h000123, 16'd0,  0, 0, 0,  24'h000000, 24'h000000, 0};
        tbl[4] = '{24'h000100, 16'd12, 1, 1, 12, 24'h000100, 24'h00010B, 0};
        tbl[5] = '{24'hABCDEF, 16'd9,  1, 0, 9,  24'hABCDEF, 24'hABCDF7, 0};

        rst_pend = 1; step();
        rst_pend = 1; step();
        step();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req_ready", req_ready, 1);

        for (int i = 0; i < 6; i++) begin
            crm = tbl[i].crm; orm = tbl[i].orm;
            start_req(tbl[i].addr, tbl[i].len);
            wait_done();
            chk("ncmd", ncmd, tbl[i].ncmd);
            chk("nout", nout, tbl[i].len);
            if (tbl[i].ncmd > 0) begin
                chk("first_addr", first_a, tbl[i].first_a);
                chk("last_addr", last_a, tbl[i].last_a);
            end
            if (tbl[i].tight) begin
                chk("cmd_latency", first_cyc - req_cyc, 1);
                chk("cmd_span", last_cyc - first_cyc, int'(tbl[i].len) - 1);
            end
        end

        crm = 0; orm = 2;
        start_req(24'h000200, 16'd20);
        repeat (40) step();
        chk("stall_cmds", ncmd, DEPTH);
        chk("stall_cmd_valid", cmd_valid, 0);
        orm = 0;
        wait_done();
        chk("stall_ncmd", ncmd, 20);
        chk("stall_nout", nout, 20);

        crm = 1; orm = 1;
        start_req(24'h000040, 16'd16);
        for (int n = 0; n < 3000 && nout < 5; n++) step();
        chk("pre_rst_words", nout, 5);
        rst_pend = 1; step();
        ndone = 0;
        step();
        chk("abort_cmd_valid", cmd_valid, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_last", out_last, 0);
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", req_ready, 1);
        repeat (5) step();
        chk("abort_no_done", ndone, 0);
        start_req(24'h0000F0, 16'd2);
        wait_done();
        chk("post_rst_nout", nout, 2);
        chk("post_rst_first", first_a, 24'h0000F0);
        chk("post_rst_last", last_a, 24'h0000F1);

        crm = 1; orm = 1;
        for (int k = 0; k < 6; k++) begin
            start_req(AW'($urandom()), LW'($urandom_range(1, 30)));
            wait_done();
            chk("rand_nout", nout, rq_len);
            chk("rand_ncmd", ncmd, rq_len);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
